ladybird_aclint_responder: RTL and testbench

- AXI responder that implements the ACLINT machine timer and machine software interrupt register blocks addressed by the core's AXI master.
- Owns a free-running 64-bit mtime counter, drives the core's rtc input, and raises the timer and software interrupt lines.
- Sits on the core's AXI bus beside the simulation memory; the interconnect routes the ACLINT window here.

---
 rtl/ladybird_aclint_responder_pkg.sv | 32 +++
 rtl/ladybird_axi_interface.sv | 35 +++
 rtl/ladybird_aclint_responder_mtime_counter.sv | 33 +++
 rtl/ladybird_aclint_responder.sv | 201 ++++++++++++++++++++
 tb/tb_ladybird_aclint_responder.sv | 284 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/ladybird_aclint_responder_pkg.sv
// Shared ACLINT constants: register offsets, AXI response codes, register
// selector type and the byte-lane merge helper.
package ladybird_config;

  localparam logic [15:0] MSIP_OFF_DEFAULT     = 16'h0000;
  localparam logic [15:0] MTIMECMP_OFF_DEFAULT = 16'h4000;
  localparam logic [15:0] MTIME_OFF_DEFAULT    = 16'hBFF8;
  localparam logic [15:0] SETSSIP_OFF          = 16'hC000;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [2:0] {
    SEL_NONE,
    SEL_MSIP,
    SEL_CMP_LO,
    SEL_CMP_HI,
    SEL_MTIME_LO,
    SEL_MTIME_HI,
    SEL_SSIP
  } reg_sel_e;

  function automatic logic [31:0] merge_word(input logic [31:0] old_w,
                                             input logic [31:0] new_w,
                                             input logic [3:0]  strb);
    merge_word = old_w;
    for (int i = 0; i < 4; i++) begin
      if (strb[i]) merge_word[i*8 +: 8] = new_w[i*8 +: 8];
    end
  endfunction

endpackage

// File: rtl/ladybird_axi_interface.sv
// Minimal AXI4-Lite style bundle shared by the core master and its responders.
interface ladybird_axi_interface #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  // Every channel transfers on a cycle where valid and ready are both high;
  // a valid, once raised, holds its payload stable until that cycle.
  logic              awvalid;
  logic              awready;
  logic [ADDR_W-1:0] awaddr;
  logic              wvalid;
  logic              wready;
  logic [DATA_W-1:0] wdata;
  logic [DATA_W/8-1:0] wstrb;
  logic              bvalid;
  logic              bready;
  logic [1:0]        bresp;
  logic              arvalid;
  logic              arready;
  logic [ADDR_W-1:0] araddr;
  logic              rvalid;
  logic              rready;
  logic [DATA_W-1:0] rdata;
  logic [1:0]        rresp;

  modport slave (
    input  awvalid, awaddr, wvalid, wdata, wstrb, bready, arvalid, araddr, rready,
    output awready, wready, bvalid, bresp, arready, rvalid, rdata, rresp
  );

  modport master (
    output awvalid, awaddr, wvalid, wdata, wstrb, bready, arvalid, araddr, rready,
    input  awready, wready, bvalid, bresp, arready, rvalid, rdata, rresp
  );
endinterface

// File: rtl/ladybird_aclint_responder_mtime_counter.sv
// Prescaled free-running 64-bit mtime counter with per-half write override.
module ladybird_mtime_counter #(
  parameter int PRESCALE = 100
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        wr_lo,
  input  logic        wr_hi,
  input  logic [31:0] wr_data,
  output logic [63:0] mtime
);
  localparam int CW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [CW-1:0] LAST = CW'(PRESCALE - 1);

  logic [CW-1:0] count;

  always_ff @(posedge clk) begin
    if (rst) begin
      mtime <= '0;
      count <= '0;
    end else if (wr_lo || wr_hi) begin
      // A software write wins over this cycle's tick and restarts the prescaler.
      count <= '0;
      if (wr_lo) mtime[31:0]  <= wr_data;
      if (wr_hi) mtime[63:32] <= wr_data;
    end else if (count == LAST) begin
      count <= '0;
      mtime <= mtime + 64'd1;
    end else begin
      count <= count + 1'b1;
    end
  end
endmodule

// File: rtl/ladybird_aclint_responder.sv
// ACLINT MTIMER/MSWI responder on the core AXI bus; defining
// LADYBIRD_ACLINT_SSWI_EN adds the setssip register and ssip output.
module ladybird_aclint_responder
  import ladybird_config::*;
#(
  parameter int          AXI_DATA_W      = 32,
  parameter int          AXI_ADDR_W      = 32,
  parameter int          PRESCALE        = 100,
  parameter logic [15:0] MSIP_OFFSET     = MSIP_OFF_DEFAULT,
  parameter logic [15:0] MTIMECMP_OFFSET = MTIMECMP_OFF_DEFAULT,
  parameter logic [15:0] MTIME_OFFSET    = MTIME_OFF_DEFAULT
) (
  input  logic                 clk,
  input  logic                 rst,
  ladybird_axi_interface.slave axi,
  output logic [63:0]          rtc,
  output logic                 mtip,
  output logic                 msip
`ifdef LADYBIRD_ACLINT_SSWI_EN
  ,
  output logic                 ssip
`endif
);

  typedef enum logic [1:0] {W_IDLE, W_EXEC, W_RESP} w_state_e;
  typedef enum logic {R_IDLE, R_RESP} r_state_e;

  w_state_e w_state, w_next;
  r_state_e r_state, r_next;

  logic                  live;
  logic                  aw_held, w_held;
  logic [15:0]           aw_off;
  logic [AXI_DATA_W-1:0] w_data;
  logic [3:0]            w_strb;
  logic [1:0]            bresp_q, rresp_q;
  logic [AXI_DATA_W-1:0] rdata_q;
  logic [63:0]           mtime, mtimecmp;
  logic                  msip_q, ssip_bit;
  logic                  aw_hs, w_hs, ar_hs, exec;
  reg_sel_e              wr_sel, rd_sel;
  logic [31:0]           wr_merged, rd_value;
  logic                  unused_addr_hi;

  function automatic reg_sel_e decode(input logic [15:0] off);
    decode = SEL_NONE;
    if (off == MSIP_OFFSET)                  decode = SEL_MSIP;
    else if (off == MTIMECMP_OFFSET)         decode = SEL_CMP_LO;
    else if (off == MTIMECMP_OFFSET + 16'd4) decode = SEL_CMP_HI;
    else if (off == MTIME_OFFSET)            decode = SEL_MTIME_LO;
    else if (off == MTIME_OFFSET + 16'd4)    decode = SEL_MTIME_HI;
`ifdef LADYBIRD_ACLINT_SSWI_EN
    else if (off == SETSSIP_OFF)             decode = SEL_SSIP;
`endif
    if (off[1:0] != 2'b00) decode = SEL_NONE;
  endfunction

  function automatic logic [31:0] reg_value(input reg_sel_e    sel,
                                            input logic        msip_b,
                                            input logic        ssip_b,
                                            input logic [63:0] cmp,
                                            input logic [63:0] tim);
    reg_value = '0;
    case (sel)
      SEL_MSIP:     reg_value = {31'b0, msip_b};
      SEL_CMP_LO:   reg_value = cmp[31:0];
      SEL_CMP_HI:   reg_value = cmp[63:32];
      SEL_MTIME_LO: reg_value = tim[31:0];
      SEL_MTIME_HI: reg_value = tim[63:32];
      SEL_SSIP:     reg_value = {31'b0, ssip_b};
      default:      reg_value = '0;
    endcase
  endfunction

  assign unused_addr_hi = ^{axi.awaddr[AXI_ADDR_W-1:16], axi.araddr[AXI_ADDR_W-1:16]};

  // Readies stay low through reset and for the first cycle after it.
  assign axi.awready = live && (w_state == W_IDLE) && !aw_held;
  assign axi.wready  = live && (w_state == W_IDLE) && !w_held;
  assign axi.bvalid  = (w_state == W_RESP);
  assign axi.bresp   = bresp_q;
  assign axi.arready = live && (r_state == R_IDLE);
  assign axi.rvalid  = (r_state == R_RESP);
  assign axi.rdata   = rdata_q;
  assign axi.rresp   = rresp_q;

  assign aw_hs = axi.awvalid && axi.awready;
  assign w_hs  = axi.wvalid && axi.wready;
  assign ar_hs = axi.arvalid && axi.arready;
  assign exec  = (w_state == W_EXEC);

  assign wr_sel    = decode(aw_off);
  assign wr_merged = merge_word(reg_value(wr_sel, msip_q, ssip_bit, mtimecmp, mtime),
                                w_data, w_strb);
  assign rd_sel    = decode(axi.araddr[15:0]);
  assign rd_value  = reg_value(rd_sel, msip_q, ssip_bit, mtimecmp, mtime);

  ladybird_mtime_counter #(.PRESCALE(PRESCALE)) u_mtime (
    .clk     (clk),
    .rst     (rst),
    .wr_lo   (exec && (wr_sel == SEL_MTIME_LO)),
    .wr_hi   (exec && (wr_sel == SEL_MTIME_HI)),
    .wr_data (wr_merged),
    .mtime   (mtime)
  );

  always_comb begin
    w_next = w_state;
    case (w_state)
      W_IDLE:  if ((aw_held || aw_hs) && (w_held || w_hs)) w_next = W_EXEC;
      W_EXEC:  w_next = W_RESP;
      W_RESP:  if (axi.bready) w_next = W_IDLE;
      default: w_next = W_IDLE;
    endcase
  end

  always_comb begin
    r_next = r_state;
    case (r_state)
      R_IDLE:  if (ar_hs) r_next = R_RESP;
      R_RESP:  if (axi.rready) r_next = R_IDLE;
      default: r_next = R_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      live     <= 1'b0;
      w_state  <= W_IDLE;
      aw_held  <= 1'b0;
      w_held   <= 1'b0;
      aw_off   <= '0;
      w_data   <= '0;
      w_strb   <= '0;
      bresp_q  <= RESP_OKAY;
      mtimecmp <= '1;
      msip_q   <= 1'b0;
    end else begin
      live    <= 1'b1;
      w_state <= w_next;
      if (aw_hs) begin
        aw_off  <= axi.awaddr[15:0];
        aw_held <= 1'b1;
      end
      if (w_hs) begin
        w_data <= axi.wdata;
        w_strb <= axi.wstrb;
        w_held <= 1'b1;
      end
      if (exec) begin
        bresp_q <= (wr_sel == SEL_NONE) ? RESP_SLVERR : RESP_OKAY;
        case (wr_sel)
          SEL_MSIP:   msip_q          <= wr_merged[0];
          SEL_CMP_LO: mtimecmp[31:0]  <= wr_merged;
          SEL_CMP_HI: mtimecmp[63:32] <= wr_merged;
          default:    ;
        endcase
      end
      if ((w_state == W_RESP) && axi.bready) begin
        aw_held <= 1'b0;
        w_held  <= 1'b0;
      end
    end
  end

`ifdef LADYBIRD_ACLINT_SSWI_EN
  logic ssip_q;
  always_ff @(posedge clk) begin
    if (rst) ssip_q <= 1'b0;
    else if (exec && (wr_sel == SEL_SSIP)) ssip_q <= wr_merged[0];
  end
  assign ssip_bit = ssip_q;
  assign ssip     = ssip_q;
`else
  assign ssip_bit = 1'b0;
`endif

  // Reads sample registers before any same-edge write commit.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= R_IDLE;
      rdata_q <= '0;
      rresp_q <= RESP_OKAY;
    end else begin
      r_state <= r_next;
      if (ar_hs) begin
        rdata_q <= (rd_sel == SEL_NONE) ? '0 : rd_value;
        rresp_q <= (rd_sel == SEL_NONE) ? RESP_SLVERR : RESP_OKAY;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) mtip <= 1'b0;
    else     mtip <= (mtime >= mtimecmp);
  end

  assign rtc  = mtime;
  assign msip = msip_q;

endmodule

// File: tb/tb_ladybird_aclint_responder.sv
// Directed bench for ladybird_aclint_responder with PRESCALE=4.
module tb_ladybird_aclint_responder;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [63:0] rtc;
  logic        mtip, msip;
`ifdef LADYBIRD_ACLINT_SSWI_EN
  logic        ssip;
`endif

  int total = 0;
  int bad   = 0;

  logic [63:0] rtc_at_b;
  logic        msip_at_b, mtip_at_b;
  int          b_wait;

  ladybird_axi_interface axi_if ();

  ladybird_aclint_responder #(.PRESCALE(4)) dut (
    .clk  (clk),
    .rst  (rst),
    .axi  (axi_if),
    .rtc  (rtc),
    .mtip (mtip),
    .msip (msip)
`ifdef LADYBIRD_ACLINT_SSWI_EN
    ,
    .ssip (ssip)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic axi_write(input logic [31:0] addr, input logic [31:0] data,
                           input logic [3:0] strb, output logic [1:0] resp);
    bit aw_done, w_done, hs_aw, hs_w;
    int n;
    aw_done = 0; w_done = 0; n = 0;
    @(negedge clk);
    axi_if.awvalid = 1'b1; axi_if.awaddr = addr;
    axi_if.wvalid  = 1'b1; axi_if.wdata  = data; axi_if.wstrb = strb;
    axi_if.bready  = 1'b1;
    while (!(aw_done && w_done) && n < 20) begin
      hs_aw = axi_if.awvalid && axi_if.awready;
      hs_w  = axi_if.wvalid && axi_if.wready;
      @(posedge clk); #1;
      if (hs_aw) begin aw_done = 1; axi_if.awvalid = 1'b0; end
      if (hs_w)  begin w_done = 1;  axi_if.wvalid  = 1'b0; end
      if (!(aw_done && w_done)) begin @(negedge clk); n++; end
    end
    check("aw_w_accepted", {62'b0, aw_done, w_done}, 64'h3);
    axi_if.awvalid = 1'b0; axi_if.wvalid = 1'b0;
    b_wait = 0;
    @(negedge clk);
    while (!axi_if.bvalid && b_wait < 20) begin @(negedge clk); b_wait++; end
    check("bvalid_seen", axi_if.bvalid, 1);
    rtc_at_b = rtc; msip_at_b = msip; mtip_at_b = mtip; resp = axi_if.bresp;
    @(posedge clk); #1;
  endtask

  task automatic axi_read(input logic [31:0] addr, output logic [31:0] data,
                          output logic [1:0] resp, output int wait_n);
    bit hs;
    int n;
    hs = 0; n = 0;
    @(negedge clk);
    axi_if.arvalid = 1'b1; axi_if.araddr = addr; axi_if.rready = 1'b1;
    while (!hs && n < 20) begin
      hs = axi_if.arready;
      @(posedge clk); #1;
      if (!hs) begin @(negedge clk); n++; end
    end
    axi_if.arvalid = 1'b0;
    check("ar_accepted", hs, 1);
    wait_n = 0;
    @(negedge clk);
    while (!axi_if.rvalid && wait_n < 20) begin @(negedge clk); wait_n++; end
    check("rvalid_seen", axi_if.rvalid, 1);
    data = axi_if.rdata; resp = axi_if.rresp;
    @(posedge clk); #1;
  endtask

  task automatic wr(input string tag, input logic [31:0] addr, input logic [31:0] data,
                    input logic [3:0] strb, input logic [1:0] exp_resp);
    logic [1:0] resp;
    axi_write(addr, data, strb, resp);
    check({tag, "_bresp"}, resp, exp_resp);
    check({tag, "_blat"}, b_wait, 1);
  endtask

  task automatic rd(input string tag, input logic [31:0] addr,
                    input logic [31:0] exp_data, input logic [1:0] exp_resp);
    logic [31:0] data;
    logic [1:0]  resp;
    int          lat;
    axi_read(addr, data, resp, lat);
    check({tag, "_rdata"}, data, exp_data);
    check({tag, "_rresp"}, resp, exp_resp);
    check({tag, "_rlat"}, lat, 0);
  endtask

  initial begin
    logic [63:0] prev_rtc;
    logic [31:0] rd_a;
    logic [1:0]  rs_a, resp_a;
    int          n, lat_a;

    axi_if.awvalid = 0; axi_if.awaddr = '0; axi_if.wvalid = 0; axi_if.wdata = '0;
    axi_if.wstrb = '0; axi_if.bready = 1; axi_if.arvalid = 0; axi_if.araddr = '0;
    axi_if.rready = 1;

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_rtc", rtc, 0);
    check("rst_mtip", mtip, 0);
    check("rst_msip", msip, 0);
    check("rst_awready", axi_if.awready, 0);
    check("rst_wready", axi_if.wready, 0);
    check("rst_arready", axi_if.arready, 0);
    check("rst_bvalid", axi_if.bvalid, 0);
    check("rst_rvalid", axi_if.rvalid, 0);
    check("rst_rdata", axi_if.rdata, 0);
    check("rst_resp", {axi_if.bresp, axi_if.rresp}, 0);
    rst = 0;

    rd("mtime_lo_rst", 32'h0000_BFF8, 32'h0, 2'b00);
    rd("mtime_hi_rst", 32'h0000_BFFC, 32'h0, 2'b00);
    rd("cmp_lo_rst", 32'h0000_4000, 32'hFFFF_FFFF, 2'b00);
    rd("cmp_hi_rst", 32'h0000_4004, 32'hFFFF_FFFF, 2'b00);
    check("mtip_after_rst", mtip, 0);

    // 40 idle cycles at PRESCALE=4 give ten ticks
    rst = 1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 0;
    repeat (40) @(posedge clk);
    @(negedge clk);
    check("idle40_rtc", rtc, 64'd10);

    // mtime half writes; the counter itself carries across halves
    wr("mtime_hi0", 32'h0000_BFFC, 32'h0, 4'hF, 2'b00);
    wr("mtime_lo", 32'h0000_BFF8, 32'hFFFF_FFFE, 4'hF, 2'b00);
    check("mtime_lo_commit", rtc_at_b, 64'h0000_0000_FFFF_FFFE);
    repeat (7) @(posedge clk);
    @(negedge clk);
    check("mtime_after8", rtc, 64'h1_0000_0000);
    wr("mtime_hi5", 32'h0000_BFFC, 32'h5, 4'hF, 2'b00);
    check("mtime_hi_commit", rtc_at_b, 64'h5_0000_0000);
    rd("mtime_hi_read", 32'h0000_BFFC, 32'h5, 2'b00);

    // mtimecmp: high first, then low; mtip rises exactly at mtime == cmp
    wr("cmp_hi", 32'h0000_4004, 32'h5, 4'hF, 2'b00);
    wr("cmp_lo", 32'h0000_4000, 32'h14, 4'hF, 2'b00);
    @(negedge clk);
    check("mtip_before", mtip, 0);
    n = 0;
    prev_rtc = rtc;
    while (!mtip && n < 200) begin
      prev_rtc = rtc;
      @(negedge clk);
      n++;
    end
    check("mtip_rose", mtip, 1);
    check("mtip_rise_point", prev_rtc, 64'h5_0000_0014);
    wr("cmp_lo_max", 32'h0000_4000, 32'hFFFF_FFFF, 4'hF, 2'b00);
    check("mtip_at_commit", mtip_at_b, 1);
    @(negedge clk);
    check("mtip_dropped", mtip, 0);

    // Byte-lane merge and empty strobe
    wr("cmp_hi_merge", 32'h0000_4004, 32'hAABB_CCDD, 4'b0101, 2'b00);
    rd("cmp_hi_merge", 32'h0000_4004, 32'h00BB_00DD, 2'b00);
    wr("cmp_lo_nostrb", 32'h0000_4000, 32'h0, 4'b0000, 2'b00);
    rd("cmp_lo_nostrb", 32'h0000_4000, 32'hFFFF_FFFF, 2'b00);

    // msip
    wr("msip_set", 32'h0, 32'h1, 4'b0001, 2'b00);
    check("msip_set_out", msip_at_b, 1);
    rd("msip_set", 32'h0, 32'h1, 2'b00);
    wr("msip_clr", 32'h0, 32'hFFFF_FFFE, 4'hF, 2'b00);
    check("msip_clr_out", msip_at_b, 0);
    rd("msip_clr", 32'h0, 32'h0, 2'b00);
    wr("msip_lane1", 32'h0, 32'h1, 4'b0010, 2'b00);
    check("msip_lane1_out", msip_at_b, 0);

    // W before AW, bready held low for 5 cycles
    @(negedge clk);
    axi_if.bready = 0;
    axi_if.wvalid = 1; axi_if.wdata = 32'h1; axi_if.wstrb = 4'b0001;
    @(posedge clk); #1;
    axi_if.wvalid = 0;
    @(negedge clk);
    axi_if.awvalid = 1; axi_if.awaddr = 32'h0;
    @(posedge clk); #1;
    axi_if.awvalid = 0;
    n = 0;
    @(negedge clk);
    while (!axi_if.bvalid && n < 20) begin @(negedge clk); n++; end
    check("wfirst_blat", n, 1);
    for (int i = 0; i < 5; i++) begin
      check("bvalid_held", axi_if.bvalid, 1);
      check("bresp_held", axi_if.bresp, 2'b00);
      @(negedge clk);
    end
    check("wfirst_msip", msip, 1);
    axi_if.bready = 1;
    @(posedge clk); #1;
    @(negedge clk);
    check("bvalid_released", axi_if.bvalid, 0);

    // Read landing on the commit edge sees the old value
    fork
      wr("msip_race", 32'h0, 32'h0, 4'hF, 2'b00);
      begin
        @(negedge clk);
        axi_read(32'h0, rd_a, rs_a, lat_a);
      end
    join
    check("race_pre_value", rd_a, 32'h1);
    rd("msip_after_race", 32'h0, 32'h0, 2'b00);

    // Error responses
    rd("misaligned", 32'h0000_0002, 32'h0, 2'b10);
    rd("cmp_plus8", 32'h0000_4008, 32'h0, 2'b10);
`ifdef LADYBIRD_ACLINT_SSWI_EN
    wr("ssip_set", 32'h0000_C000, 32'h1, 4'hF, 2'b00);
    check("ssip_out", ssip, 1);
    rd("ssip_read", 32'h0000_C000, 32'h1, 2'b00);
`else
    rd("ssip_unmapped", 32'h0000_C000, 32'h0, 2'b10);
`endif
    wr("wr_misaligned", 32'h0000_0002, 32'h1, 4'hF, 2'b10);
    check("wr_misaligned_msip", msip_at_b, 0);

    // Concurrent write and unmapped read
    fork
      wr("conc_write", 32'h0, 32'h1, 4'hF, 2'b00);
      axi_read(32'h0000_2000, rd_a, rs_a, lat_a);
    join
    check("conc_rdata", rd_a, 32'h0);
    check("conc_rresp", rs_a, 2'b10);
    check("conc_msip", msip, 1);

    // Reset mid-transaction drops the write with no response
    @(negedge clk);
    axi_if.awvalid = 1; axi_if.awaddr = 32'h0; axi_if.wvalid = 1; axi_if.wdata = 32'h0;
    axi_if.wstrb = 4'hF;
    @(posedge clk); #1;
    axi_if.awvalid = 0; axi_if.wvalid = 0;
    rst = 1;
    @(posedge clk);
    @(negedge clk);
    check("abort_bvalid", axi_if.bvalid, 0);
    check("abort_msip", msip, 0);
    check("abort_rtc", rtc, 0);
    rst = 0;
    repeat (3) @(negedge clk);
    check("abort_no_b", axi_if.bvalid, 0);

    // 64-bit wrap
    wr("wrap_hi", 32'h0000_BFFC, 32'hFFFF_FFFF, 4'hF, 2'b00);
    wr("wrap_lo", 32'h0000_BFF8, 32'hFFFF_FFFF, 4'hF, 2'b00);
    check("wrap_commit", rtc_at_b, 64'hFFFF_FFFF_FFFF_FFFF);
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("wrap_zero", rtc, 64'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
